uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; CPB = CLK_HZ/BAUD, integer truncation (434 at defaults); CPB >= 16 required.
REQ-003 i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 o_data  output  8  received byte, stable while o_valid=1.
REQ-007 o_valid  output  1  byte available; held until accepted.
REQ-008 i_ready  input  1  consumer accept; transfer occurs on a cycle with o_valid=1 and i_ready=1.
REQ-009 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 o_overrun  output  1  one-cycle pulse: completed byte dropped because holding register was full.
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 i_rxd passes through a 2-flop synchronizer; all further references to "line" mean the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_HIGH; single bit-timing counter cnt and 3-bit bit index idx.
REQ-014 IDLE: on rxs falling edge (previous 1, current 0) go to START with cnt=0.
REQ-015 START: when cnt reaches CPB/2-1, sample rxs; 0 -> DATA with cnt=0, idx=0; 1 -> false start, back to IDLE, no output pulse.
REQ-016 DATA: when cnt reaches CPB-1, sample rxs into shift register bit idx (LSB first), cnt=0; after idx=7 go to STOP, else idx+1.
REQ-017 STOP: when cnt reaches CPB-1, sample rxs; 1 -> byte complete, go to IDLE; 0 -> o_frame_err pulse next cycle, byte discarded, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rxs=1, then IDLE; falling edges ignored while in WAIT_HIGH (break condition never produces bytes).
REQ-019 Byte complete with o_valid=0: next cycle o_data=shifted byte, o_valid=1.
REQ-020 Byte complete with o_valid=1 and i_ready=1 same cycle: old byte transferred, new byte loaded, o_valid stays 1, no overrun.
REQ-021 Byte complete with o_valid=1 and i_ready=0: new byte dropped, o_data unchanged, o_overrun pulses one cycle.
REQ-022 Transfer without completion: o_valid cleared next cycle; o_data retains last value.
REQ-023 Return to IDLE after stop sample allows a falling edge in the very next cycle to start a new frame (back-to-back frames with no idle gap).
REQ-024 Latency: o_valid rises 1 cycle after the stop-bit sample cycle; stop sample occurs CPB/2+9*CPB cycles (±1) after the synchronized falling edge.
REQ-025 o_frame_err and o_overrun never assert together and never for more than one cycle per event.

Reset
REQ-026 While i_rst=1: state=IDLE, cnt=0, idx=0, shift register=0, synchronizer flops=1, o_data=0x00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-027 Reset mid-frame aborts the frame with no output pulse; after release a line already low produces no start until it returns high and falls again.
REQ-028 After release, first frame is received normally with no residual pulse.

Verification
REQ-029 Defaults, i_ready=1, send 0x55 then 0xA3 back-to-back -> two o_valid beats, o_data=0x55 then 0xA3, no error pulses.
REQ-030 Low glitch of 100 cycles on idle line -> no o_valid, o_busy high then low, back in IDLE before CPB cycles.
REQ-031 Send 0x3C with stop bit low, then line high -> single o_frame_err pulse, no o_valid; following 0x7E received correctly.
REQ-032 i_ready=0, send 0x11 then 0x22 -> o_valid=1, o_data=0x11, o_overrun one pulse at second completion; assert i_ready -> o_valid drops, o_data remains 0x11.
REQ-033 i_rst pulsed at bit 4 of a frame -> all outputs reset values, no pulse; next full frame 0x81 received correctly.
REQ-034 Line held low 20*CPB (break) -> one o_frame_err, no o_valid, no further activity until line high.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The line is synchronized and then sampled in the middle of each bit.
// A one-entry holding register feeds a valid/ready consumer.
// A stop bit sampled low produces a framing-error pulse and then waits for the line to go idle.
// A completed byte that cannot be stored produces an overrun pulse.
module uart_rx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int CPB   = CLK_HZ / BAUD;
   localparam int CNT_W = $clog2(CPB);

   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CPB / 2) - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       idx_r;
   logic [7:0]       shift_r;
   logic             sync1_r;
   logic             rxs_r;
   logic             prev_r;
   logic [1:0]       settle_r;
   logic             fall_s;

   // A falling edge counts only once both synchronizer flops hold real line samples taken after reset.
   // prev_r resets low, so a line that is already low at release must first return high.
   assign fall_s = settle_r[1] & prev_r & ~rxs_r;

   // Two-flop synchronizer, previous-sample register, and post-reset settle tracker.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_r  <= 1'b1;
         rxs_r    <= 1'b1;
         prev_r   <= 1'b0;
         settle_r <= 2'b00;
      end else begin
         sync1_r  <= i_rxd;
         rxs_r    <= sync1_r;
         settle_r <= {settle_r[0], 1'b1};
         if (settle_r[1]) begin
            prev_r <= rxs_r;
         end else begin
            prev_r <= 1'b0;
         end
      end
   end

   // Receive FSM together with the holding register and the registered status outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         idx_r       <= 3'd0;
         shift_r     <= 8'h00;
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end else begin
            o_valid <= o_valid;
         end
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               idx_r <= 3'd0;
               if (fall_s) begin
                  state_r <= ST_START;
                  o_busy  <= 1'b1;
               end else begin
                  o_busy  <= 1'b0;
               end
            end
            ST_START: begin
               if (cnt_r == CNT_HALF) begin
                  cnt_r <= '0;
                  idx_r <= 3'd0;
                  if (!rxs_r) begin
                     state_r <= ST_DATA;
                  end else begin
                     // Line went high again before mid-bit, so this was a glitch.
                     state_r <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt_r == CNT_BIT) begin
                  cnt_r          <= '0;
                  shift_r[idx_r] <= rxs_r;
                  if (idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end else begin
                     idx_r <= idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (cnt_r == CNT_BIT) begin
                  cnt_r <= '0;
                  if (rxs_r) begin
                     state_r <= ST_IDLE;
                     o_busy  <= 1'b0;
                     if (!o_valid || i_ready) begin
                        // Holding register is empty or is being emptied this cycle.
                        o_data  <= shift_r;
                        o_valid <= 1'b1;
                     end else begin
                        o_overrun <= 1'b1;
                     end
                  end else begin
                     o_frame_err <= 1'b1;
                     state_r     <= ST_WAIT_HIGH;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_WAIT_HIGH: begin
               cnt_r <= '0;
               if (rxs_r) begin
                  state_r <= ST_IDLE;
                  o_busy  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT_HIGH;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               idx_r   <= 3'd0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
